// File: rtl/saradc_nb_dig_scan_seq.sv
// SAR scan sequencer: masked channel scan with per-channel oversampling.
// Optional limit monitor enabled by SARADC_SEQ_LIMIT_EN.
module saradc_nb_dig_scan_seq #(
  parameter int SAR_BITS     = 11,
  parameter int N_CHANNELS   = 8,
  parameter int OVS_MAX_LOG2 = 3,
  parameter int TRACK_CYC    = 4,
  localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int RES_W = SAR_BITS + OVS_MAX_LOG2
) (
  input  logic                  clk_i,
  input  logic                  res_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [N_CHANNELS-1:0] chmask_i,
  input  logic [2:0]            ovs_cfg_i,
  input  logic                  comp_i,
`ifdef SARADC_SEQ_LIMIT_EN
  input  logic [RES_W-1:0]      lim_lo_i,
  input  logic [RES_W-1:0]      lim_hi_i,
  output logic [N_CHANNELS-1:0] lim_o,
`endif
  output logic                  busy_o,
  output logic [N_CHANNELS-1:0] sample_ch_o,
  output logic [SAR_BITS-1:0]   din_o,
  output logic                  eoc_o,
  output logic [CH_W-1:0]       chnr_o,
  output logic [RES_W-1:0]      result_o
);

  localparam int TW = (TRACK_CYC > 1) ? $clog2(TRACK_CYC) : 1;
  localparam int BW = $clog2(SAR_BITS);
  localparam int SW = OVS_MAX_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONV,
    S_ACC,
    S_RESULT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [N_CHANNELS-1:0] mask_q;
  logic [2:0]            ovs_q;
  logic [CH_W-1:0]       ch;
  logic [TW-1:0]         trk_cnt;
  logic [BW-1:0]         bit_idx;
  logic [SAR_BITS-1:0]   code;
  logic [RES_W-1:0]      acc;
  logic [SW-1:0]         smp_cnt;

  logic [CH_W-1:0]  first_ch;
  logic             first_vld;
  logic [CH_W-1:0]  next_ch;
  logic             next_vld;
  logic [2:0]       ovs_cl;
  logic [SW-1:0]    n_smp;
  logic             start_ok;
  logic             trk_done;
  logic             conv_done;
  logic             smp_last;
  logic [RES_W-1:0] res_norm;

  // Lowest set channel of the incoming mask.
  always_comb begin
    first_ch  = '0;
    first_vld = 1'b0;
    for (int j = N_CHANNELS - 1; j >= 0; j--) begin
      if (chmask_i[j]) begin
        first_ch  = CH_W'(j);
        first_vld = 1'b1;
      end
    end
  end

  // Next set channel strictly above the current one; no wrap.
  always_comb begin
    next_ch  = '0;
    next_vld = 1'b0;
    for (int j = N_CHANNELS - 1; j >= 0; j--) begin
      if (mask_q[j] && (j > int'(ch))) begin
        next_ch  = CH_W'(j);
        next_vld = 1'b1;
      end
    end
  end

  assign ovs_cl = (int'(ovs_cfg_i) > OVS_MAX_LOG2) ?
                  3'(OVS_MAX_LOG2) : ovs_cfg_i;
  assign n_smp     = SW'(1) << ovs_q;
  assign start_ok  = start_i && first_vld;
  assign trk_done  = (trk_cnt == TW'(TRACK_CYC - 1));
  assign conv_done = (bit_idx == '0);
  assign smp_last  = (smp_cnt == (n_smp - SW'(1)));
  assign res_norm  = acc << (OVS_MAX_LOG2 - int'(ovs_q));

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop_i) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   if (start_ok) state_nxt = S_SAMPLE;
        S_SAMPLE: if (trk_done) state_nxt = S_CONV;
        S_CONV:   if (conv_done) state_nxt = S_ACC;
        S_ACC:    state_nxt = smp_last ? S_RESULT : S_SAMPLE;
        S_RESULT: state_nxt = next_vld ? S_SAMPLE : S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o      = (state != S_IDLE);
    sample_ch_o = '0;
    din_o       = '0;
    if (state == S_SAMPLE) sample_ch_o = N_CHANNELS'(1) << ch;
    if (state == S_CONV)   din_o = code | (SAR_BITS'(1) << bit_idx);
  end

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      mask_q   <= '0;
      ovs_q    <= '0;
      ch       <= '0;
      trk_cnt  <= '0;
      bit_idx  <= '0;
      code     <= '0;
      acc      <= '0;
      smp_cnt  <= '0;
      eoc_o    <= 1'b0;
      chnr_o   <= '0;
      result_o <= '0;
    end else begin
      eoc_o <= 1'b0;
      if (!stop_i) begin
        unique case (state)
          S_IDLE: begin
            if (start_ok) begin
              mask_q  <= chmask_i;
              ovs_q   <= ovs_cl;
              ch      <= first_ch;
              acc     <= '0;
              smp_cnt <= '0;
              trk_cnt <= '0;
            end
          end
          S_SAMPLE: begin
            trk_cnt <= trk_done ? '0 : trk_cnt + TW'(1);
            code    <= '0;
            bit_idx <= BW'(SAR_BITS - 1);
          end
          S_CONV: begin
            code[bit_idx] <= comp_i;
            if (!conv_done) bit_idx <= bit_idx - BW'(1);
          end
          S_ACC: begin
            acc     <= acc + RES_W'(code);
            smp_cnt <= smp_last ? '0 : smp_cnt + SW'(1);
          end
          S_RESULT: begin
            result_o <= res_norm;
            chnr_o   <= ch;
            eoc_o    <= 1'b1;
            acc      <= '0;
            if (next_vld) ch <= next_ch;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SARADC_SEQ_LIMIT_EN
  // Sticky out-of-window flags, one per channel.
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      lim_o <= '0;
    end else if (!stop_i) begin
      if ((state == S_IDLE) && start_ok) begin
        lim_o <= '0;
      end else if (state == S_RESULT) begin
        if ((res_norm < lim_lo_i) || (res_norm > lim_hi_i))
          lim_o[ch] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_saradc_nb_dig_scan_seq.sv
// Bench for saradc_nb_dig_scan_seq: ideal comparator, schedule-based
// reference model checked every cycle, plus literal anchor values.
module tb_saradc_nb_dig_scan_seq;

  localparam int SB = 11;
  localparam int NC = 8;
  localparam int OM = 3;
  localparam int TC = 4;
  localparam int CW = 3;
  localparam int RW = 14;
  localparam int PH = TC + SB + 1;

  logic          clk_i = 1'b0;
  logic          res_i;
  logic          start_i;
  logic          stop_i;
  logic [NC-1:0] chmask_i;
  logic [2:0]    ovs_cfg_i;
  logic          comp_i;
  logic          busy_o;
  logic [NC-1:0] sample_ch_o;
  logic [SB-1:0] din_o;
  logic          eoc_o;
  logic [CW-1:0] chnr_o;
  logic [RW-1:0] result_o;
`ifdef SARADC_SEQ_LIMIT_EN
  logic [RW-1:0] lim_lo_i;
  logic [RW-1:0] lim_hi_i;
  logic [NC-1:0] lim_o;
`endif

  int checks = 0;
  int failures = 0;
  int cur_vin = 0;
  int vin [NC][8];
  int chl [NC];
  int nch;
  int eoc_t;
  int din_t5;
  int eoc_chs[$];
  logic [RW-1:0] exp_res;
  logic [CW-1:0] exp_ch;

  saradc_nb_dig_scan_seq dut (
    .clk_i       (clk_i),
    .res_i       (res_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .chmask_i    (chmask_i),
    .ovs_cfg_i   (ovs_cfg_i),
    .comp_i      (comp_i),
`ifdef SARADC_SEQ_LIMIT_EN
    .lim_lo_i    (lim_lo_i),
    .lim_hi_i    (lim_hi_i),
    .lim_o       (lim_o),
`endif
    .busy_o      (busy_o),
    .sample_ch_o (sample_ch_o),
    .din_o       (din_o),
    .eoc_o       (eoc_o),
    .chnr_o      (chnr_o),
    .result_o    (result_o)
  );

  always #5 clk_i = ~clk_i;

  assign comp_i = (cur_vin >= int'(din_o));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40)
        $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fill_rand();
    for (int c = 0; c < NC; c++)
      for (int s = 0; s < 8; s++)
        vin[c][s] = int'($urandom_range(0, (1 << SB) - 1));
  endtask

  // Expected outputs derived from the scan schedule: each channel takes
  // 2^ovs samples of PH cycles, then one result cycle.
  task automatic run_scan(input logic [NC-1:0] mask, input logic [2:0] ovs,
                          input int stop_t);
    int ov, ns, d, total, st, i, u, s, p, b, v, j, sum;
    logic [NC-1:0] e_smp;
    logic [SB-1:0] e_din;
    logic e_busy, e_eoc;
    ov = (int'(ovs) > OM) ? OM : int'(ovs);
    ns = 1 << ov;
    d = ns * PH + 1;
    nch = 0;
    for (int c = 0; c < NC; c++)
      if (mask[c]) begin
        chl[nch] = c;
        nch++;
      end
    total = nch * d;
    st = (stop_t > 0) ? stop_t : (1 << 30);
    eoc_t = -1;
    din_t5 = -1;
    eoc_chs.delete();
    @(negedge clk_i);
    chmask_i = mask;
    ovs_cfg_i = ovs;
    start_i = 1'b1;
    for (int t = 1; t <= total + 4; t++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      stop_i = 1'b0;
      chmask_i = NC'($urandom);
      ovs_cfg_i = 3'($urandom);
      if (t >= 2 && t < total && t < st && $urandom_range(0, 15) == 0)
        start_i = 1'b1;
      if (t == st) stop_i = 1'b1;
      e_busy = (t <= total) && (t <= st);
      e_smp = '0;
      e_din = '0;
      e_eoc = 1'b0;
      cur_vin = 0;
      i = (t - 1) / d;
      u = (t - 1) % d;
      if (e_busy && u < ns * PH) begin
        s = u / PH;
        p = u % PH;
        v = vin[i][s];
        cur_vin = v;
        if (p < TC) begin
          e_smp = NC'(1) << chl[i];
        end else if (p < TC + SB) begin
          b = SB - 1 - (p - TC);
          e_din = SB'(((v >> (b + 1)) << (b + 1)) | (1 << b));
        end
      end
      if (t >= 2 && (t - 1) % d == 0 && (t - 1) / d <= nch && (t - 1) < st) begin
        j = (t - 1) / d - 1;
        sum = 0;
        for (int k = 0; k < ns; k++) sum += vin[j][k];
        e_eoc = 1'b1;
        exp_res = RW'(sum << (OM - ov));
        exp_ch = CW'(chl[j]);
      end
      chk("busy", 32'(busy_o), 32'(e_busy));
      chk("sample_ch", 32'(sample_ch_o), 32'(e_smp));
      chk("din", 32'(din_o), 32'(e_din));
      chk("eoc", 32'(eoc_o), 32'(e_eoc));
      chk("result", 32'(result_o), 32'(exp_res));
      chk("chnr", 32'(chnr_o), 32'(exp_ch));
      if (t == 5) din_t5 = int'(din_o);
      if (eoc_o) begin
        if (eoc_t < 0) eoc_t = t;
        eoc_chs.push_back(int'(chnr_o));
      end
    end
  endtask

  initial begin
    res_i = 1'b1;
    start_i = 1'b0;
    stop_i = 1'b0;
    chmask_i = '0;
    ovs_cfg_i = '0;
    exp_res = '0;
    exp_ch = '0;
`ifdef SARADC_SEQ_LIMIT_EN
    lim_lo_i = RW'(14'h0400);
    lim_hi_i = RW'(14'h3000);
`endif
    repeat (3) @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_result", 32'(result_o), 32'd0);
    chk("rst_eoc", 32'(eoc_o), 32'd0);
    chk("rst_sample", 32'(sample_ch_o), 32'd0);
    res_i = 1'b0;

    // Single channel, vin 0x2AB.
    vin[0][0] = 32'h2AB;
    run_scan(8'h01, 3'd0, 0);
    chk("t1_eoc_cycle", 32'(eoc_t), 32'd18);
    chk("t1_din_msb", 32'(din_t5), 32'h400);
    chk("t1_result", 32'(result_o), 32'h1558);
    chk("t1_chnr", 32'(chnr_o), 32'd0);

    // Three channels in order 2,5,7.
    fill_rand();
    run_scan(8'hA4, 3'd0, 0);
    chk("t2_neoc", 32'(eoc_chs.size()), 32'd3);
    if (eoc_chs.size() == 3) begin
      chk("t2_ch0", 32'(eoc_chs[0]), 32'd2);
      chk("t2_ch1", 32'(eoc_chs[1]), 32'd5);
      chk("t2_ch2", 32'(eoc_chs[2]), 32'd7);
    end

    // ovs=2 with a ramp of samples.
    for (int k = 0; k < 4; k++) vin[0][k] = 32'h100 + k;
    run_scan(8'h01, 3'd2, 0);
    chk("t3_eoc_cycle", 32'(eoc_t), 32'd66);
    chk("t3_result", 32'(result_o), 32'h080C);

    // ovs clamp to 3 with full-scale input.
    for (int k = 0; k < 8; k++) vin[0][k] = 32'h7FF;
    run_scan(8'h01, 3'd7, 0);
    chk("t4_result", 32'(result_o), 32'h3FF8);

    // Empty mask start is ignored.
    run_scan(8'h00, 3'd0, 0);
    chk("t5_busy", 32'(busy_o), 32'd0);

    // Stop during CONV of channel 5.
    fill_rand();
    run_scan(8'hA4, 3'd0, 25);
    chk("t6_neoc", 32'(eoc_chs.size()), 32'd1);
    chk("t6_result_kept", 32'(result_o), 32'(RW'(vin[0][0] << 3)));

    // Stop together with start in IDLE.
    @(negedge clk_i);
    start_i = 1'b1;
    stop_i = 1'b1;
    chmask_i = 8'hFF;
    @(negedge clk_i);
    start_i = 1'b0;
    stop_i = 1'b0;
    chk("t7_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    chk("t7_busy2", 32'(busy_o), 32'd0);

    // Randomized scans, some aborted.
    for (int r = 0; r < 10; r++) begin
      logic [NC-1:0] m;
      logic [2:0] o;
      int stp;
      fill_rand();
      m = NC'($urandom);
      o = 3'($urandom);
      stp = 0;
      if ($urandom_range(0, 3) == 0) stp = int'($urandom_range(1, 300));
      run_scan(m, o, stp);
    end

    // Asynchronous reset mid-SAMPLE.
    vin[0][0] = 32'h155;
    @(negedge clk_i);
    chmask_i = 8'h01;
    ovs_cfg_i = 3'd0;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    chk("t8_sampling", 32'(sample_ch_o), 32'h01);
    res_i = 1'b1;
    #1;
    chk("t8_busy", 32'(busy_o), 32'd0);
    chk("t8_sample", 32'(sample_ch_o), 32'd0);
    chk("t8_result", 32'(result_o), 32'd0);
    chk("t8_chnr", 32'(chnr_o), 32'd0);
    chk("t8_din", 32'(din_o), 32'd0);
    @(negedge clk_i);
    res_i = 1'b0;
    exp_res = '0;
    exp_ch = '0;

`ifdef SARADC_SEQ_LIMIT_EN
    vin[0][0] = 32'h010;
    run_scan(8'h02, 3'd0, 0);
    chk("lim_set", 32'(lim_o), 32'h02);
    vin[0][0] = 32'h2AB;
    run_scan(8'h01, 3'd0, 0);
    chk("lim_clear", 32'(lim_o), 32'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
